// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 Wishbone loader slice: register offsets,
// CTRL/STATUS bit positions, sequencer state encoding and the SHA-1 initial
// hash constants used by the round engine.
package sha1_pkg;

  // Register byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_DATA    = 8'h08;
  localparam logic [7:0] OFF_DIGEST0 = 8'h10;
  localparam logic [7:0] OFF_DIGEST1 = 8'h14;
  localparam logic [7:0] OFF_DIGEST2 = 8'h18;
  localparam logic [7:0] OFF_DIGEST3 = 8'h1C;
  localparam logic [7:0] OFF_DIGEST4 = 8'h20;

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_INIT  = 1;
  localparam int CTRL_CLR   = 2;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_CNT_LSB = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_DIG = 2'd2
  } sha1_state_t;

  // SHA-1 initial hash values, reloaded by the engine when w_init_o is set
  localparam logic [31:0] SHA1_H0 = 32'h6745_2301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCD_AB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BA_DCFE;
  localparam logic [31:0] SHA1_H3 = 32'h1032_5476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2_E1F0;

  // Assemble the STATUS register image
  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       done,
                                              input logic       ovf,
                                              input logic       err,
                                              input logic [4:0] cnt);
    pack_status = {23'd0, cnt, err, ovf, done, busy};
  endfunction

endpackage

// File: rtl/sha1_wb_loader_if.sv
// Wishbone classic slave bus bundle for the SHA-1 loader.
interface sha1_wb_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sha1_wb_regif.sv
// Wishbone register front end: address decode, single-cycle ack, registered
// read mux, and one-cycle command strobes for the loader sequencer. Strobes
// are asserted in the same cycle as the ack.
import sha1_pkg::*;

module sha1_wb_regif #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  sha1_wb_loader_if.slave wb,
  input  logic           busy_s,
  input  logic           done_r,
  input  logic           ovf_r,
  input  logic           err_r,
  input  logic [4:0]     wr_cnt_r,
  input  logic [159:0]   digest_r,
  output logic           push_r,
  output logic [31:0]    push_data_r,
  output logic           start_r,
  output logic           init_r,
  output logic           clr_r,
  output logic           done_clr_r
);

  logic        hit_s;
  logic        access_s;
  logic        wr_s;
  logic [7:0]  off_s;
  logic [31:0] rd_data_s;
  logic        ack_r;
  logic [31:0] dat_r;
  logic        unused_sel_s;

  // Byte selects carry no meaning here: every access is a full word
  assign unused_sel_s = ^wb.wbs_sel_i;

  // Address decode and access qualification; ack blocks a second access
  always_comb begin
    hit_s    = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    off_s    = wb.wbs_adr_i[7:0];
    access_s = wb.wbs_stb_i & wb.wbs_cyc_i & hit_s & ~ack_r;
    wr_s     = access_s & wb.wbs_we_i;
  end

  // Read mux; write-only and unmapped offsets read as zero
  always_comb begin
    case (off_s)
      OFF_STATUS:  rd_data_s = pack_status(busy_s, done_r, ovf_r, err_r, wr_cnt_r);
      OFF_DIGEST0: rd_data_s = digest_r[159:128];
      OFF_DIGEST1: rd_data_s = digest_r[127:96];
      OFF_DIGEST2: rd_data_s = digest_r[95:64];
      OFF_DIGEST3: rd_data_s = digest_r[63:32];
      OFF_DIGEST4: rd_data_s = digest_r[31:0];
      default:     rd_data_s = 32'd0;
    endcase
  end

  // Ack, read data and command strobe registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'd0;
      push_r      <= 1'b0;
      push_data_r <= 32'd0;
      start_r     <= 1'b0;
      init_r      <= 1'b0;
      clr_r       <= 1'b0;
      done_clr_r  <= 1'b0;
    end else begin
      ack_r      <= access_s;
      dat_r      <= (access_s & ~wb.wbs_we_i) ? rd_data_s : 32'd0;
      push_r     <= wr_s & (off_s == OFF_DATA);
      start_r    <= wr_s & (off_s == OFF_CTRL) & wb.wbs_dat_i[CTRL_START];
      init_r     <= wr_s & (off_s == OFF_CTRL) & wb.wbs_dat_i[CTRL_INIT];
      clr_r      <= wr_s & (off_s == OFF_CTRL) & wb.wbs_dat_i[CTRL_CLR];
      done_clr_r <= wr_s & (off_s == OFF_STATUS) & wb.wbs_dat_i[ST_DONE];
      if (wr_s) begin
        push_data_r <= wb.wbs_dat_i;
      end
    end
  end

  assign wb.wbs_ack_o = ack_r;
  assign wb.wbs_dat_o = dat_r;

endmodule

// File: rtl/sha1_wb_loader.sv
// SHA-1 Wishbone loader: buffers one 16-word message block written by
// firmware, streams it to the round engine over valid/ready, and captures the
// returned 160-bit digest for readback.
// Build option: define SHA1_LOADER_IRQ_EN to get a registered done interrupt
// on irq_o; otherwise irq_o is tied low and done is polled through STATUS.
import sha1_pkg::*;

module sha1_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NWORDS    = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  sha1_wb_loader_if.slave wb,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [31:0]     w_data_o,
  output logic            w_last_o,
  output logic            w_init_o,
  input  logic            digest_valid_i,
  input  logic [159:0]    digest_i,
  output logic            irq_o
);

  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  sha1_state_t       state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic [31:0]       buf_r [NWORDS];
  logic              w_valid_r;
  logic [31:0]       w_data_r;
  logic              w_last_r;
  logic              w_init_r;
  logic              done_r;
  logic              ovf_r;
  logic              err_r;
  logic [159:0]      digest_r;

  logic              push_s;
  logic [31:0]       push_data_s;
  logic              start_s;
  logic              init_s;
  logic              clr_s;
  logic              done_clr_s;
  logic              busy_s;
  logic              full_s;
  logic              hs_s;
  logic              done_evt_s;
  logic [IDX_W-1:0]  idx_nxt_s;

  sha1_wb_regif #(.BASE_ADDR(BASE_ADDR)) u_regif (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_i),
    .wb          (wb),
    .busy_s      (busy_s),
    .done_r      (done_r),
    .ovf_r       (ovf_r),
    .err_r       (err_r),
    .wr_cnt_r    (wr_cnt_r),
    .digest_r    (digest_r),
    .push_r      (push_s),
    .push_data_r (push_data_s),
    .start_r     (start_s),
    .init_r      (init_s),
    .clr_r       (clr_s),
    .done_clr_r  (done_clr_s)
  );

  // Sequencer status terms
  always_comb begin
    busy_s     = (state_r != IDLE);
    full_s     = (wr_cnt_r == FULL_CNT);
    hs_s       = w_valid_r & w_ready_i;
    done_evt_s = (state_r == WAIT_DIG) & digest_valid_i;
    idx_nxt_s  = idx_r + IDX_W'(1);
  end

  // Block buffer, word sequencer FSM, sticky flags and digest capture
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      wr_cnt_r  <= '0;
      w_valid_r <= 1'b0;
      w_data_r  <= 32'd0;
      w_last_r  <= 1'b0;
      w_init_r  <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
      digest_r  <= 160'd0;
    end else begin
      // Word pushes are only accepted while idle and not full
      if (push_s) begin
        if ((state_r == IDLE) && !full_s) begin
          buf_r[wr_cnt_r[IDX_W-1:0]] <= push_data_s;
          wr_cnt_r                   <= wr_cnt_r + CNT_W'(1);
        end else begin
          ovf_r <= 1'b1;
        end
      end

      if (done_clr_s) begin
        done_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start_s && !clr_s) begin
            if (full_s) begin
              w_init_r  <= init_s;
              idx_r     <= '0;
              w_valid_r <= 1'b1;
              w_data_r  <= buf_r[0];
              w_last_r  <= (LAST_IDX == '0);
              state_r   <= STREAM;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (start_s) begin
            err_r <= 1'b1;
          end
          // Data and valid only move on a completed handshake
          if (hs_s) begin
            if (idx_r == LAST_IDX) begin
              w_valid_r <= 1'b0;
              w_last_r  <= 1'b0;
              state_r   <= WAIT_DIG;
            end else begin
              idx_r    <= idx_nxt_s;
              w_data_r <= buf_r[idx_nxt_s];
              w_last_r <= (idx_nxt_s == LAST_IDX);
            end
          end
        end
        WAIT_DIG: begin
          if (start_s) begin
            err_r <= 1'b1;
          end
          if (digest_valid_i) begin
            digest_r <= digest_i;
            done_r   <= 1'b1;
            wr_cnt_r <= '0;
            w_init_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          w_valid_r <= 1'b0;
          w_last_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase

      // CLR overrides every other flag and counter update in the same cycle
      if (clr_s) begin
        wr_cnt_r <= '0;
        done_r   <= 1'b0;
        ovf_r    <= 1'b0;
        err_r    <= 1'b0;
      end
    end
  end

  assign w_valid_o = w_valid_r;
  assign w_data_o  = w_data_r;
  assign w_last_o  = w_last_r;
  assign w_init_o  = w_init_r;

`ifdef SHA1_LOADER_IRQ_EN
  logic irq_r;

  // Done interrupt level: set with done, cleared by the STATUS done write-1
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      irq_r <= 1'b0;
    end else if (done_evt_s) begin
      irq_r <= 1'b1;
    end else if (done_clr_s) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq_o = irq_r;
`else
  logic unused_done_evt_s;

  assign unused_done_evt_s = done_evt_s;
  assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_wb_loader.sv
// Directed self-checking bench for sha1_wb_loader.
module tb_sha1_wb_loader;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_DATA   = BASE + 32'h08;
  localparam logic [31:0] A_DIG0   = BASE + 32'h10;
  localparam logic [159:0] ABC_DIG =
    160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
`ifdef SHA1_LOADER_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [31:0]  w_data_o;
  logic         w_last_o;
  logic         w_init_o;
  logic         digest_valid_i;
  logic [159:0] digest_i;
  logic         irq_o;

  int total = 0;
  int bad   = 0;

  // Handshake monitor state
  int          cap_cnt = 0;
  logic [31:0] cap_data [0:31];
  logic        cap_last [0:31];
  logic        cap_init [0:31];
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;

  sha1_wb_loader_if wbif ();

  sha1_wb_loader #(.BASE_ADDR(32'h3000_0000), .NWORDS(16)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst_n),
    .wb             (wbif),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready_i),
    .w_data_o       (w_data_o),
    .w_last_o       (w_last_o),
    .w_init_o       (w_init_o),
    .digest_valid_i (digest_valid_i),
    .digest_i       (digest_i),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  // Record accepted words and detect changes while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!w_valid_o || (w_data_o !== prev_data))) stall_viol++;
      if (w_valid_o && w_ready_i) begin
        if (cap_cnt < 32) begin
          cap_data[cap_cnt] = w_data_o;
          cap_last[cap_cnt] = w_last_o;
          cap_init[cap_cnt] = w_init_o;
        end
        cap_cnt++;
      end
      prev_stall = w_valid_o && !w_ready_i;
      prev_data  = w_data_o;
    end
  end

  function automatic logic [31:0] abc_word(input int i);
    if (i == 0) return 32'h6162_6380;
    else if (i == 15) return 32'h0000_0018;
    else return 32'h0000_0000;
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    wbif.wbs_adr_i = a; wbif.wbs_dat_i = d; wbif.wbs_we_i = 1'b1;
    wbif.wbs_sel_i = 4'hF; wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!wbif.wbs_ack_o && n < 8);
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0; wbif.wbs_we_i = 1'b0;
    total++;
    if (wbif.wbs_ack_o !== 1'b1) begin
      bad++; $display("FAIL write_ack adr=%h got=%b exp=1", a, wbif.wbs_ack_o);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    wbif.wbs_adr_i = a; wbif.wbs_we_i = 1'b0; wbif.wbs_sel_i = 4'hF;
    wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!wbif.wbs_ack_o && n < 8);
    d = wbif.wbs_dat_o;
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0;
    total++;
    if (wbif.wbs_ack_o !== 1'b1) begin
      bad++; $display("FAIL read_ack adr=%h got=%b exp=1", a, wbif.wbs_ack_o);
    end
  endtask

  // Drive w_ready_i (optionally with 1-5 cycle stalls) until 16 words are taken
  task automatic run_stream(input bit stall);
    int n = 0; int left = 0; bit ok = 1'b0;
    while (n < 400 && !ok) begin
      @(posedge clk); #1; n++;
      if (cap_cnt >= 16) ok = 1'b1;
      else if (!stall) w_ready_i = 1'b1;
      else if (left > 0) begin w_ready_i = 1'b0; left--; end
      else if ($urandom_range(0, 1) == 1) begin
        w_ready_i = 1'b0; left = $urandom_range(1, 5) - 1;
      end else w_ready_i = 1'b1;
    end
    w_ready_i = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL stream_done got=%0d exp=16", cap_cnt); end
  endtask

  task automatic pulse_digest(input logic [159:0] d);
    digest_i = d; digest_valid_i = 1'b1;
    @(posedge clk); #1;
    digest_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({wbif.wbs_ack_o, w_valid_o, w_last_o, w_init_o, irq_o} !== 5'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=00000",
                      {wbif.wbs_ack_o, w_valid_o, w_last_o, w_init_o, irq_o});
    end
    total++;
    if (wbif.wbs_dat_o !== 32'd0) begin
      bad++; $display("FAIL reset_dat got=%h exp=0", wbif.wbs_dat_o);
    end
    rst_n = 1'b1;
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", rd); end
    wb_read(A_DIG0, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL reset_h0 got=%h exp=0", rd); end
  endtask

  task automatic test_abc();
    logic [31:0] rd;
    logic [31:0] exp_h;
    cap_cnt = 0;
    for (int i = 0; i < 16; i++) wb_write(A_DATA, abc_word(i));
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_0100) begin bad++; $display("FAIL abc_full got=%h exp=100", rd); end
    wb_write(A_CTRL, 32'h3);
    run_stream(1'b0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({cap_data[i], cap_last[i], cap_init[i]} !== {abc_word(i), (i == 15), 1'b1}) begin
        bad++; $display("FAIL abc_word%0d got=%h/%b/%b exp=%h/%b/1", i, cap_data[i],
                        cap_last[i], cap_init[i], abc_word(i), (i == 15));
      end
    end
    total++;
    if (w_valid_o !== 1'b0) begin bad++; $display("FAIL abc_valid_drop got=%b exp=0", w_valid_o); end
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_0101) begin bad++; $display("FAIL abc_waitdig got=%h exp=101", rd); end
    pulse_digest(ABC_DIG);
    total++;
    if (irq_o !== IRQ_EXP) begin bad++; $display("FAIL abc_irq_set got=%b exp=%b", irq_o, IRQ_EXP); end
    for (int k = 0; k < 5; k++) begin
      wb_read(A_DIG0 + 32'(4 * k), rd);
      exp_h = ABC_DIG[159 - 32 * k -: 32];
      total++;
      if (rd !== exp_h) begin bad++; $display("FAIL abc_h%0d got=%h exp=%h", k, rd, exp_h); end
    end
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_0002) begin bad++; $display("FAIL abc_done got=%h exp=2", rd); end
    wb_write(A_STATUS, 32'h2);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL abc_done_clr got=%h exp=0", rd); end
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL abc_irq_clr got=%b exp=0", irq_o); end
  endtask

  task automatic test_stalls();
    logic [31:0] rd;
    cap_cnt = 0; stall_viol = 0;
    for (int i = 0; i < 16; i++) wb_write(A_DATA, 32'h1111_0000 + 32'(i));
    wb_write(A_CTRL, 32'h1);
    run_stream(1'b1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({cap_data[i], cap_init[i]} !== {32'h1111_0000 + 32'(i), 1'b0}) begin
        bad++; $display("FAIL stall_word%0d got=%h/%b exp=%h/0", i, cap_data[i],
                        cap_init[i], 32'h1111_0000 + 32'(i));
      end
    end
    total++;
    if (stall_viol !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (cap_cnt !== 16) begin bad++; $display("FAIL stall_count got=%0d exp=16", cap_cnt); end
    pulse_digest(160'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C);
    wb_read(A_DIG0 + 32'h10, rd);
    total++;
    if (rd !== 32'h0F1E_2D3C) begin bad++; $display("FAIL stall_h4 got=%h exp=0f1e2d3c", rd); end
    wb_write(A_STATUS, 32'h2);
  endtask

  task automatic test_ovf_err();
    logic [31:0] rd;
    cap_cnt = 0;
    for (int i = 0; i < 16; i++) wb_write(A_DATA, 32'hB0B0_0000 + 32'(i));
    wb_write(A_DATA, 32'hDEAD_BEEF);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_0104) begin bad++; $display("FAIL ovf_status got=%h exp=104", rd); end
    wb_write(A_CTRL, 32'h3);
    run_stream(1'b0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_data[i] !== 32'hB0B0_0000 + 32'(i)) begin
        bad++; $display("FAIL ovf_buf%0d got=%h exp=%h", i, cap_data[i], 32'hB0B0_0000 + 32'(i));
      end
    end
    pulse_digest(160'h1);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_0006) begin bad++; $display("FAIL ovf_sticky got=%h exp=6", rd); end
    wb_write(A_CTRL, 32'h4);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL clr_status got=%h exp=0", rd); end
    for (int i = 0; i < 10; i++) wb_write(A_DATA, 32'(i));
    wb_write(A_CTRL, 32'h1);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'h0000_00A8) begin bad++; $display("FAIL err_start got=%h exp=a8", rd); end
    total++;
    if (w_valid_o !== 1'b0) begin bad++; $display("FAIL err_novalid got=%b exp=0", w_valid_o); end
    for (int i = 0; i < 6; i++) wb_write(A_DATA, 32'(i));
    wb_write(A_CTRL, 32'h5);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL clr_wins got=%h exp=0", rd); end
    total++;
    if (w_valid_o !== 1'b0) begin bad++; $display("FAIL clr_wins_valid got=%b exp=0", w_valid_o); end
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    int acks; int consec; int dat_bad;
    logic prev_ack;
    wb_read(BASE + 32'h30, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL rd_unmapped got=%h exp=0", rd); end
    wb_read(A_CTRL, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL rd_ctrl got=%h exp=0", rd); end
    wb_write(BASE + 32'h30, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) wb_write(A_DATA, 32'h7);
    // Held strobe: expect ack every other cycle with data only during ack
    @(posedge clk); #1;
    acks = 0; consec = 0; dat_bad = 0; prev_ack = 1'b0;
    wbif.wbs_adr_i = A_STATUS; wbif.wbs_we_i = 1'b0;
    wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wbif.wbs_ack_o) begin
        acks++;
        if (prev_ack) consec++;
        if (wbif.wbs_dat_o !== 32'h0000_0030) dat_bad++;
      end else if (wbif.wbs_dat_o !== 32'd0) dat_bad++;
      prev_ack = wbif.wbs_ack_o;
    end
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0;
    total++;
    if (acks !== 3 || consec !== 0) begin
      bad++; $display("FAIL b2b_acks got=%0d/%0d exp=3/0", acks, consec);
    end
    total++;
    if (dat_bad !== 0) begin bad++; $display("FAIL b2b_dat got=%0d exp=0", dat_bad); end
    @(posedge clk); #1;
    total++;
    if (wbif.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL ack_width got=%b exp=0", wbif.wbs_ack_o); end
    // Outside the decoded window: no ack ever
    acks = 0;
    wbif.wbs_adr_i = 32'h3000_0104; wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wbif.wbs_ack_o) acks++;
    end
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0;
    total++;
    if (acks !== 0) begin bad++; $display("FAIL oor_ack got=%0d exp=0", acks); end
    wb_write(A_CTRL, 32'h4);
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL bus_clr got=%h exp=0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n = 0;
    cap_cnt = 0;
    for (int i = 0; i < 16; i++) wb_write(A_DATA, 32'hC0C0_0000 + 32'(i));
    wb_write(A_CTRL, 32'h3);
    w_ready_i = 1'b1;
    while (cap_cnt < 7 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (cap_cnt !== 7) begin bad++; $display("FAIL mid_reach got=%0d exp=7", cap_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({w_valid_o, w_last_o, w_init_o, irq_o} !== 4'b0) begin
      bad++; $display("FAIL mid_outs got=%b exp=0000", {w_valid_o, w_last_o, w_init_o, irq_o});
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (cap_cnt !== 7 || w_valid_o !== 1'b0) begin
      bad++; $display("FAIL mid_abandon got=%0d/%b exp=7/0", cap_cnt, w_valid_o);
    end
    wb_read(A_STATUS, rd);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL mid_status got=%h exp=0", rd); end
    for (int k = 0; k < 5; k++) begin
      wb_read(A_DIG0 + 32'(4 * k), rd);
      total++;
      if (rd !== 32'd0) begin bad++; $display("FAIL mid_h%0d got=%h exp=0", k, rd); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0; wbif.wbs_we_i = 1'b0;
    wbif.wbs_sel_i = 4'h0; wbif.wbs_adr_i = 32'd0; wbif.wbs_dat_i = 32'd0;
    w_ready_i = 1'b1; digest_valid_i = 1'b0; digest_i = 160'd0;
    test_reset();
    test_abc();
    test_stalls();
    test_ovf_err();
    test_bus();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha1_wb_loader.md
Name: sha1_wb_loader

Overview:
- Wishbone-slave front end for the SHA-1 user project. It sits directly upstream of the SHA-1 round engine inside wrapper_sha1.
- Firmware writes 16 message words (one 512-bit block) plus control over Wishbone. The block streams the words to the engine on a valid/ready word interface.
- It captures the 160-bit digest the engine returns and exposes it for Wishbone readback.
- Padding is done in firmware. This block only buffers and sequences blocks.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base. The block decodes adr[31:8] against BASE_ADDR[31:8].
- NWORDS, 16, words per block. Fixed at 16; the parameter exists only for counter sizing.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-low
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (ignored; full-word access only)
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- w_valid_o  out  1  word valid to the engine
- w_ready_i  in  1  engine accepts the word
- w_data_o  out  32  message word, big-endian as written
- w_last_o  out  1  marks word 15 of the block
- w_init_o  out  1  engine reloads H0..H4 constants before this block (stable for the whole block)
- digest_valid_i  in  1  one-cycle pulse: digest_i is valid
- digest_i  in  160  {H0,H1,H2,H3,H4}
- irq_o  out  1  done interrupt (see Optional Feature)

Behaviour:
- Reset (wb_rst_i=0 at a clock edge):
  - outputs: wbs_ack_o=0, wbs_dat_o=0, w_valid_o=0, w_last_o=0, w_init_o=0, irq_o=0.
  - internal: wr_cnt=0, state IDLE, digest regs=0, flags (done, ovf, err)=0.
  - Reset mid-stream abandons the block. No further words are issued.
- Register map (byte offsets):
  - 0x00 CTRL (W): bit0 START, bit1 INIT, bit2 CLR (clears wr_cnt and flags).
  - 0x04 STATUS (R): bit0 busy, bit1 done, bit2 ovf, bit3 err, bits[8:4] wr_cnt. Write 1 to bit1 clears done.
  - 0x08 DATA (W): pushes one word.
  - 0x10..0x20 DIGEST H0..H4 (R).
  - Unmapped or write-only offsets read as 0. Writes to them are acked and have no effect.
- Wishbone timing:
  - Access = stb & cyc & address hit & !wbs_ack_o.
  - wbs_ack_o pulses high for exactly 1 cycle, the cycle after the access.
  - wbs_dat_o is registered, valid with ack, and 0 otherwise.
  - Back-to-back accesses give one ack per 2 cycles minimum.
- DATA write:
  - In IDLE with wr_cnt<16: store buf[wr_cnt], increment wr_cnt.
  - With wr_cnt==16, or state not IDLE: word dropped, ovf set (sticky). The write is still acked.
- START:
  - In IDLE with wr_cnt==16: latch INIT into w_init_o, go to STREAM with idx=0.
  - Otherwise: ignored, err set.
  - START and CLR in the same write: CLR wins.
- FSM:
  - IDLE -> STREAM -> WAIT_DIG -> IDLE.
  - STREAM: w_valid_o=1, w_data_o=buf[idx], w_last_o=(idx==15). idx advances only when w_valid_o & w_ready_i. On the handshake with idx==15 the block goes to WAIT_DIG the next cycle and w_valid_o drops.
  - w_valid_o and w_data_o must not change while valid is high and ready is low.
  - WAIT_DIG: on digest_valid_i, latch digest_i, set done, clear wr_cnt to 0, clear w_init_o, go to IDLE.
  - digest_valid_i in any other state is ignored.
- busy = (state != IDLE).
- Minimum block latency from the START ack to the first w_valid_o is 1 cycle.

Optional Feature:
- Macro: SHA1_LOADER_IRQ_EN.
- Defined: irq_o is a level set on the cycle done rises, cleared by the STATUS bit1 write-1 or by reset. It is registered, with no combinational path from digest_valid_i.
- Undefined: irq_o is tied 0. There is no IRQ register, and done remains pollable.

Decomposition:
- Shared package sha1_pkg holds:
  - register offset localparams (CTRL, STATUS, DATA, DIGEST0..4);
  - STATUS and CTRL bit indices;
  - the FSM state enum {IDLE, STREAM, WAIT_DIG};
  - the H0..H4 init constants, for the engine.
- One sub-module: sha1_wb_regif, which handles the Wishbone decode, ack generation, and read mux. It feeds push, start, and clear strobes to the sequencer in sha1_wb_loader.

Test Plan:
- Write 16 words 0x61626380, 0, …, 0x00000018 (the "abc" block), then CTRL=0x3. Expect 16 handshakes in order, with w_last_o only on the 16th and w_init_o=1. Drive the digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D. Expect the DIGEST reads to match, STATUS.done=1, and wr_cnt=0.
- Engine stalls (random w_ready_i low for 1–5 cycles). Expect w_data_o and w_valid_o held stable across stalls and no word skipped or duplicated.
- Write a 17th DATA word. Expect ack, ovf=1, and buf unchanged. Issue START with wr_cnt=10: expect err=1 and state stays IDLE.
- Assert wb_rst_i=0 at word 7 of STREAM. Next cycle expect w_valid_o=0, all STATUS bits 0, and DIGEST reads 0.
- Check every access yields exactly one 1-cycle ack. Read of offset 0x30 returns 0. Out-of-range address (adr[31:8] mismatch) gets no ack.
- With SHA1_LOADER_IRQ_EN defined, irq_o rises 1 cycle after digest_valid_i and clears after a STATUS write of 0x2. Without the macro, irq_o stays 0 throughout.
